// File: rtl/img_stream_pkg.sv
// Shared types and defaults for the row-parallel image stream blocks.
package img_stream_pkg;

  localparam int ROW_PIX = 256;
  localparam int COL_PIX = 256;
  localparam int PIX_W   = 24;
  localparam int CH_W    = 8;

  localparam int R_OFF = 16;
  localparam int G_OFF = 8;
  localparam int B_OFF = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/row_out_slot.sv
// Single-entry output register for one assembled row and its row index.
module row_out_slot #(
  parameter int ROW_W = 96,
  parameter int RW    = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic             consume,
  input  logic [ROW_W-1:0] data,
  input  logic [RW-1:0]    idx,
  input  logic             last,
  output logic [ROW_W-1:0] row_out,
  output logic             row_valid,
  output logic [RW-1:0]    row_idx,
  output logic             last_row
);

  // A load always wins over a consume so back-to-back rows keep row_valid high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      row_out   <= {ROW_W{1'b0}};
      row_valid <= 1'b0;
      row_idx   <= {RW{1'b0}};
      last_row  <= 1'b0;
    end else if (load) begin
      row_out   <= data;
      row_valid <= 1'b1;
      row_idx   <= idx;
      last_row  <= last;
    end else if (consume) begin
      row_valid <= 1'b0;
      last_row  <= 1'b0;
    end
  end

endmodule

// File: rtl/row_stream_packer.sv
// Packs a raster RGB pixel stream into full-row words with row/frame tracking.
module row_stream_packer
  import img_stream_pkg::*;
#(
  parameter int COLS  = ROW_PIX,
  parameter int ROWS  = COL_PIX,
  parameter int PIX_W = img_stream_pkg::PIX_W
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       start,
  input  logic [PIX_W-1:0]           pix_in,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  output logic [COLS*PIX_W-1:0]      row_out,
  output logic                       row_valid,
  input  logic                       row_ready,
  output logic [cnt_w(ROWS)-1:0]     row_idx,
  output logic                       last_row,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int CW    = cnt_w(COLS);
  localparam int RW    = cnt_w(ROWS);
  localparam int ROW_W = COLS * PIX_W;

  state_t           state_r, state_next_s;
  logic [CW-1:0]    col_cnt_r;
  logic [RW-1:0]    row_cnt_r;
  logic [PIX_W-1:0] buf_r [COLS];
  logic             pix_ready_r, busy_r, frame_done_r;

  logic             pix_hs_s, last_col_s, last_rowcnt_s;
  logic             consume_s, slot_free_s, load_s, use_pix_s, done_s;
  logic [ROW_W-1:0] row_data_s;

  assign pix_hs_s      = (state_r == FILL) && pix_valid;
  assign last_col_s    = (col_cnt_r == CW'(COLS - 1));
  assign last_rowcnt_s = (row_cnt_r == RW'(ROWS - 1));
  assign consume_s     = row_valid && row_ready;
  assign slot_free_s   = !row_valid || row_ready;

  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    use_pix_s    = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = FILL;
        else       state_next_s = IDLE;
      end
      FILL: begin
        if (pix_hs_s && last_col_s) begin
          if (slot_free_s) begin
            load_s       = 1'b1;
            use_pix_s    = 1'b1;
            state_next_s = last_rowcnt_s ? DRAIN : FILL;
          end else begin
            state_next_s = HOLD;
          end
        end else begin
          state_next_s = FILL;
        end
      end
      HOLD: begin
        if (consume_s) begin
          load_s       = 1'b1;
          state_next_s = last_rowcnt_s ? DRAIN : FILL;
        end else begin
          state_next_s = HOLD;
        end
      end
      DRAIN: begin
        if (consume_s) begin
          done_s       = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = DRAIN;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Row word: pixel 0 in the MSBs; the closing pixel bypasses the buffer on a direct load.
  always_comb begin
    row_data_s = {ROW_W{1'b0}};
    for (int c = 0; c < COLS; c++) begin
      row_data_s[(COLS-1-c)*PIX_W +: PIX_W] = buf_r[c];
    end
    if (use_pix_s) row_data_s[PIX_W-1:0] = pix_in;
    else           row_data_s[PIX_W-1:0] = buf_r[COLS-1];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= IDLE;
      pix_ready_r  <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      pix_ready_r  <= (state_next_s == FILL);
      busy_r       <= (state_next_s != IDLE);
      frame_done_r <= done_s;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      col_cnt_r <= {CW{1'b0}};
      row_cnt_r <= {RW{1'b0}};
    end else if ((state_r == IDLE) && start) begin
      col_cnt_r <= {CW{1'b0}};
      row_cnt_r <= {RW{1'b0}};
    end else begin
      if (pix_hs_s) col_cnt_r <= last_col_s ? {CW{1'b0}} : col_cnt_r + CW'(1);
      if (load_s)   row_cnt_r <= last_rowcnt_s ? {RW{1'b0}} : row_cnt_r + RW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < COLS; i++) buf_r[i] <= {PIX_W{1'b0}};
    end else if (pix_hs_s) begin
      buf_r[col_cnt_r] <= pix_in;
    end
  end

  row_out_slot #(.ROW_W(ROW_W), .RW(RW)) u_slot (
    .CLK       (CLK),
    .RST       (RST),
    .load      (load_s),
    .consume   (consume_s),
    .data      (row_data_s),
    .idx       (row_cnt_r),
    .last      (last_rowcnt_s),
    .row_out   (row_out),
    .row_valid (row_valid),
    .row_idx   (row_idx),
    .last_row  (last_row)
  );

  assign pix_ready  = pix_ready_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_row_stream_packer.sv
// Scoreboard bench for row_stream_packer on a 4x2 frame with directed and random traffic.
module tb_row_stream_packer;

  localparam int COLS  = 4;
  localparam int ROWS  = 2;
  localparam int PIX_W = 24;
  localparam int RW    = 1;
  localparam int ROW_W = COLS * PIX_W;

  logic             CLK = 1'b0;
  logic             RST, start, pix_valid, pix_ready;
  logic [PIX_W-1:0] pix_in;
  logic [ROW_W-1:0] row_out;
  logic             row_valid, row_ready, last_row, busy, frame_done;
  logic [RW-1:0]    row_idx;

  row_stream_packer #(.COLS(COLS), .ROWS(ROWS), .PIX_W(PIX_W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .row_out(row_out), .row_valid(row_valid), .row_ready(row_ready),
    .row_idx(row_idx), .last_row(last_row), .busy(busy), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [ROW_W-1:0] data;
    logic [RW-1:0]    idx;
    logic             last;
  } exp_t;

  exp_t             exp_q[$];
  logic [PIX_W-1:0] acc_q[$];
  int               model_row = 0;
  int               checks = 0, failures = 0;
  int               frames_seen = 0, frames_target = 0;
  logic             rand_ready = 1'b0;

  task automatic chk(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: accepted pixels in order, COLS per row, rows counted modulo ROWS.
  task automatic model_accept(input logic [PIX_W-1:0] p);
    exp_t e;
    acc_q.push_back(p);
    if (acc_q.size() == COLS) begin
      e.data = {ROW_W{1'b0}};
      foreach (acc_q[i]) e.data = (e.data << PIX_W) | ROW_W'(acc_q[i]);
      e.idx  = RW'(model_row);
      e.last = (model_row == ROWS - 1);
      exp_q.push_back(e);
      model_row = (model_row + 1) % ROWS;
      acc_q.delete();
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; start = 1'b0; pix_valid = 1'b0; row_ready = 1'b0;
    cyc();
    exp_q.delete(); acc_q.delete(); model_row = 0;
    RST = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    acc_q.delete(); model_row = 0;
  endtask

  task automatic send_pix(input logic [PIX_W-1:0] p, input int gap);
    bit done = 1'b0;
    pix_in = p; pix_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge CLK);
      if (pix_ready) begin
        model_accept(p);
        done = 1'b1;
      end
      cyc();
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL pix_timeout actual=no_ready required=ready");
    end
    pix_valid = 1'b0;
    repeat (gap) cyc();
  endtask

  task automatic wait_frames(input int target);
    for (int i = 0; i < 300 && frames_seen < target; i++) cyc();
    chk("frame_count", ROW_W'(frames_seen), ROW_W'(target));
  endtask

  always @(posedge CLK) begin
    #1;
    if (rand_ready) row_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: pops the scoreboard on each row handshake, checks stalls and frame_done.
  logic             stall_prev = 1'b0, done_due = 1'b0;
  logic [ROW_W-1:0] prev_out;
  logic [RW-1:0]    prev_idx;
  logic             prev_last;
  exp_t             got;
  always @(negedge CLK) begin
    if (RST) begin
      stall_prev = 1'b0;
      done_due   = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", ROW_W'(row_valid), ROW_W'(1));
        chk("stall_data", row_out, prev_out);
        chk("stall_idx", ROW_W'(row_idx), ROW_W'(prev_idx));
        chk("stall_last", ROW_W'(last_row), ROW_W'(prev_last));
      end
      chk("frame_done", ROW_W'(frame_done), ROW_W'(done_due));
      if (frame_done) begin
        frames_seen++;
        chk("busy_at_done", ROW_W'(busy), ROW_W'(0));
      end
      done_due = 1'b0;
      if (row_valid && row_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_row actual=%0h required=none", row_out);
        end else begin
          got = exp_q.pop_front();
          chk("row_data", row_out, got.data);
          chk("row_idx", ROW_W'(row_idx), ROW_W'(got.idx));
          chk("last_row", ROW_W'(last_row), ROW_W'(got.last));
          if (got.last) done_due = 1'b1;
        end
      end
      stall_prev = row_valid && !row_ready;
      prev_out   = row_out;
      prev_idx   = row_idx;
      prev_last  = last_row;
    end
  end

  task automatic chk_reset_vals();
    @(negedge CLK);
    chk("rst_pix_ready", ROW_W'(pix_ready), ROW_W'(0));
    chk("rst_row_valid", ROW_W'(row_valid), ROW_W'(0));
    chk("rst_row_out", row_out, ROW_W'(0));
    chk("rst_row_idx", ROW_W'(row_idx), ROW_W'(0));
    chk("rst_last_row", ROW_W'(last_row), ROW_W'(0));
    chk("rst_busy", ROW_W'(busy), ROW_W'(0));
    chk("rst_frame_done", ROW_W'(frame_done), ROW_W'(0));
    cyc();
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_in = 24'h000000; row_ready = 1'b0;
    repeat (2) cyc();
    do_reset();
    chk_reset_vals();

    // Basic frame, row_ready held high, latency-1 row presentation.
    row_ready = 1'b1;
    do_start();
    for (int i = 1; i <= 3; i++) send_pix(PIX_W'(i), 0);
    send_pix(24'h000004, 0);
    @(negedge CLK);
    chk("latency_valid", ROW_W'(row_valid), ROW_W'(1));
    chk("row0_literal", row_out, 96'h000001_000002_000003_000004);
    cyc();
    for (int i = 5; i <= 8; i++) send_pix(PIX_W'(i), 0);
    frames_target++;
    wait_frames(frames_target);
    chk("busy_after_frame", ROW_W'(busy), ROW_W'(0));

    // Backpressure: row 1 completes while row 0 is still held.
    row_ready = 1'b0;
    do_start();
    for (int i = 0; i < 4; i++) send_pix(PIX_W'(24'h100 + i), 0);
    for (int i = 0; i < 4; i++) send_pix(PIX_W'(24'h200 + i), 0);
    @(negedge CLK);
    chk("hold_pix_ready", ROW_W'(pix_ready), ROW_W'(0));
    chk("hold_row_idx", ROW_W'(row_idx), ROW_W'(0));
    cyc();
    cyc();
    row_ready = 1'b1;
    cyc();
    @(negedge CLK);
    chk("no_bubble_valid", ROW_W'(row_valid), ROW_W'(1));
    chk("no_bubble_idx", ROW_W'(row_idx), ROW_W'(1));
    chk("no_bubble_last", ROW_W'(last_row), ROW_W'(1));
    cyc();
    frames_target++;
    wait_frames(frames_target);

    // Gapped pix_valid, pix_valid in IDLE, start pulsed mid-frame.
    pix_valid = 1'b1; pix_in = 24'hABCDEF;
    repeat (3) cyc();
    @(negedge CLK);
    chk("idle_pix_ready", ROW_W'(pix_ready), ROW_W'(0));
    chk("idle_busy", ROW_W'(busy), ROW_W'(0));
    cyc();
    pix_valid = 1'b0;
    do_start();
    send_pix(24'h0A0A0A, 1);
    send_pix(24'h0B0B0B, 1);
    start = 1'b1; cyc(); start = 1'b0;
    send_pix(24'h0C0C0C, 1);
    send_pix(24'h0D0D0D, 1);
    for (int i = 0; i < 4; i++) send_pix(PIX_W'(24'h300 + i), 0);
    frames_target++;
    wait_frames(frames_target);

    // Reset in the middle of a row, then a clean restart.
    do_start();
    send_pix(24'h111111, 0);
    send_pix(24'h222222, 0);
    do_reset();
    chk_reset_vals();
    row_ready = 1'b1;
    do_start();
    for (int i = 0; i < 4; i++) send_pix(PIX_W'(24'h400 + i), 0);
    repeat (3) cyc();
    chk("post_reset_drained", ROW_W'(exp_q.size()), ROW_W'(0));
    do_reset();

    // Random frames: random data, gaps and downstream backpressure.
    rand_ready = 1'b1;
    for (int f = 0; f < 20; f++) begin
      do_start();
      for (int p = 0; p < COLS * ROWS; p++) send_pix(PIX_W'($urandom()), $urandom_range(0, 2));
      frames_target++;
      wait_frames(frames_target);
    end
    rand_ready = 1'b0;
    cyc();
    row_ready = 1'b0;
    repeat (3) cyc();
    chk("final_queue_empty", ROW_W'(exp_q.size()), ROW_W'(0));
    chk("final_frames", ROW_W'(frames_seen), ROW_W'(frames_target));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
